tick_gen_multi: RTL and testbench

TICK_GEN_MULTI -- requirements
Module: tick_gen_multi

---
 rtl/tick_gen_multi_if.sv | 30 +++
 rtl/tick_gen_multi.sv | 93 +++++++++
 tb/tb_tick_gen_multi.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_gen_multi_if.sv
// Divisor-configuration bus for tick_gen_multi: write strobe, target channel,
// new divisor, and the one-cycle accept/reject responses.
interface tick_gen_multi_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 27
);
  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ack;
  logic             cfg_err;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_div,
    input  cfg_ack,
    input  cfg_err
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ack,
    output cfg_err
  );
endinterface

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable clock-enable generator: per-channel divide-by-D
// tick pulse and square wave, with glitch-free divisor updates and phase sync.
module tick_gen_multi #(
  parameter int unsigned            N_CH     = 4,
  parameter int unsigned            CNT_W    = 27,
  parameter logic [N_CH*CNT_W-1:0]  DIV_INIT = {27'd25000000, 27'd50000,
                                                27'd500000,   27'd1000000}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  tick_gen_multi_if.slave  cfg,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  sq
);

  logic wr_ok;
  logic wr_rej;

  // A write is legal only for an existing channel and a divisor of at least 2.
  assign wr_ok  = cfg.cfg_we && (cfg.cfg_div >= CNT_W'(2)) && (32'(cfg.cfg_ch) < N_CH);
  assign wr_rej = cfg.cfg_we && !wr_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_ack <= wr_ok;
      cfg.cfg_err <= wr_rej;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] shd_q;
    logic             pend_q;
    logic             tick_q;
    logic             sq_q;
    logic             wr_hit;
    logic             wrap;
    logic [CNT_W-1:0] div_wrap;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] half;

    assign wr_hit   = wr_ok && (32'(cfg.cfg_ch) == 32'(i));
    assign wrap     = (cnt_q == div_q - CNT_W'(1));
    // Divisor in force after a wrap or sync: the shadow only if a write is pending.
    assign div_wrap = pend_q ? shd_q : div_q;
    assign cnt_inc  = wrap ? '0 : cnt_q + CNT_W'(1);
    assign half     = (wrap ? div_wrap : div_q) >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        div_q  <= DIV_INIT[i*CNT_W +: CNT_W];
        shd_q  <= DIV_INIT[i*CNT_W +: CNT_W];
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        if (sync) begin
          cnt_q  <= '0;
          div_q  <= div_wrap;
          pend_q <= 1'b0;
          tick_q <= 1'b0;
          sq_q   <= 1'b1;
        end else if (en[i]) begin
          cnt_q  <= cnt_inc;
          tick_q <= wrap;
          sq_q   <= (cnt_inc < half);
          if (wrap) begin
            div_q  <= div_wrap;
            pend_q <= 1'b0;
          end
        end else begin
          tick_q <= 1'b0;
        end
        // A write landing with a wrap/sync becomes the next pending value.
        if (wr_hit) begin
          shd_q  <= cfg.cfg_div;
          pend_q <= 1'b1;
        end
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi: directed stimulus queues cycle-stamped
// expectations; a negedge monitor pops and compares whenever the DUT responds.
`timescale 1ns/1ps
module tb_tick_gen_multi;
  localparam int unsigned N     = 3;
  localparam int unsigned CW    = 16;

  typedef struct {
    int unsigned  cyc;
    logic [N-1:0] tick;
    logic [N-1:0] sq_care;
    logic [N-1:0] sq;
    logic         ack;
    logic         err;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] en;
  logic         sync;
  logic [N-1:0] tick;
  logic [N-1:0] sq;

  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  tick_gen_multi_if #(.N_CH(N), .CNT_W(CW)) cfg_if ();

  tick_gen_multi #(
    .N_CH    (N),
    .CNT_W   (CW),
    .DIV_INIT({16'd8, 16'd6, 16'd5})
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .sync (sync),
    .cfg  (cfg_if),
    .tick (tick),
    .sq   (sq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Insert an expectation in cycle order, merging entries for the same cycle.
  function automatic void exp_add(input int unsigned c, input logic [N-1:0] tk,
                                  input logic [N-1:0] care, input logic [N-1:0] sqv,
                                  input logic ack, input logic err, input string nm);
    exp_t e;
    int   pos;
    pos = exp_q.size();
    for (int k = 0; k < exp_q.size(); k++) begin
      if (exp_q[k].cyc == c) begin
        e = exp_q[k];
        e.tick    = e.tick | tk;
        e.sq      = (e.sq & ~care) | (sqv & care);
        e.sq_care = e.sq_care | care;
        e.ack     = e.ack | ack;
        e.err     = e.err | err;
        e.name    = {e.name, "+", nm};
        exp_q[k]  = e;
        return;
      end
      if (exp_q[k].cyc > c) begin
        pos = k;
        break;
      end
    end
    e.cyc = c; e.tick = tk; e.sq_care = care; e.sq = sqv;
    e.ack = ack; e.err = err; e.name = nm;
    exp_q.insert(pos, e);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL %s: expectation for cycle %0d never compared", mon_e.name, mon_e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (tick !== mon_e.tick || cfg_if.cfg_ack !== mon_e.ack || cfg_if.cfg_err !== mon_e.err ||
            (sq & mon_e.sq_care) !== (mon_e.sq & mon_e.sq_care)) begin
          errors++;
          $display("FAIL %s @%0d: got tick=%b ack=%b err=%b sq=%b, want tick=%b ack=%b err=%b sq=%b (mask %b)",
                   mon_e.name, cyc, tick, cfg_if.cfg_ack, cfg_if.cfg_err, sq,
                   mon_e.tick, mon_e.ack, mon_e.err, mon_e.sq, mon_e.sq_care);
        end
      end else if (tick !== '0 || cfg_if.cfg_ack !== 1'b0 || cfg_if.cfg_err !== 1'b0) begin
        checks++; errors++;
        $display("FAIL unexpected_event @%0d: got tick=%b ack=%b err=%b, want none",
                 cyc, tick, cfg_if.cfg_ack, cfg_if.cfg_err);
      end
    end
  end

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic write_cfg(input logic [1:0] ch, input logic [CW-1:0] dv,
                           input logic ok, input string nm);
    cfg_if.cfg_we  = 1'b1;
    cfg_if.cfg_ch  = ch;
    cfg_if.cfg_div = dv;
    exp_add(cyc + 1, '0, '0, '0, ok, !ok, nm);
    @(negedge clk);
    cfg_if.cfg_we  = 1'b0;
  endtask

  task automatic do_sync(output int unsigned s);
    sync = 1'b1;
    exp_add(cyc + 1, '0, '1, '1, 1'b0, 1'b0, "sync");
    @(negedge clk);
    sync = 1'b0;
    s = cyc;
  endtask

  task automatic check_zero(input string nm, input logic [N-1:0] act);
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s: got %b, want 0", nm, act);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;
    int unsigned s2;
    int unsigned r;
    rst_n = 1'b0; en = '0; sync = 1'b0;
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0;
    repeat (2) @(negedge clk);
    check_zero("reset_tick", tick);
    check_zero("reset_sq", sq);
    check_zero("reset_ack", {2'b00, cfg_if.cfg_ack});
    check_zero("reset_err", {2'b00, cfg_if.cfg_err});
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // D=4 on ch0: tick every 4 enabled cycles, sq 1,0,0,1
    write_cfg(2'd0, 16'd4, 1'b1, "wr_d4");
    do_sync(s);
    en = 3'b001;
    for (int unsigned j = 1; j <= 12; j++)
      exp_add(s + j, (j % 4 == 0) ? 3'b001 : 3'b000, 3'b001,
              ((j - 1) % 4 == 0 || (j - 1) % 4 == 3) ? 3'b001 : 3'b000, 1'b0, 1'b0, "d4_run");
    wait_until(s + 12);
    en = '0;

    // D=5 running, D=3 written at c=1: period 5 completes, then 3
    write_cfg(2'd0, 16'd5, 1'b1, "wr_d5");
    do_sync(s);
    en = 3'b001;
    exp_add(s + 1,  3'b000, 3'b001, 3'b001, 1'b0, 1'b0, "d5_sq_hi");
    exp_add(s + 2,  3'b000, 3'b001, 3'b000, 1'b0, 1'b0, "d5_sq_lo");
    exp_add(s + 5,  3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "d5_tick");
    exp_add(s + 6,  3'b000, 3'b001, 3'b000, 1'b0, 1'b0, "d3_sq_lo");
    exp_add(s + 8,  3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "d3_tick1");
    exp_add(s + 11, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "d3_tick2");
    exp_add(s + 14, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "d3_tick3");
    exp_add(s + 17, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "d3_tick4");
    exp_add(s + 20, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "d3_tick5");
    wait_until(s + 1);
    write_cfg(2'd0, 16'd3, 1'b1, "wr_d3_mid");
    // Rejected writes leave ch0 ticking every 3 cycles
    wait_until(s + 11);
    write_cfg(2'd0, 16'd1, 1'b0, "wr_d1_rej");
    write_cfg(2'd3, 16'd7, 1'b0, "wr_ch3_rej");
    write_cfg(2'd0, 16'd0, 1'b0, "wr_d0_rej");
    write_cfg(2'd2, 16'd10, 1'b1, "wr_ch2_ok");
    wait_until(s + 20);
    en = '0;

    // ch0 D=4, ch1 D=6, staggered enables, then sync realigns both
    write_cfg(2'd0, 16'd4, 1'b1, "wr_c0_d4");
    write_cfg(2'd1, 16'd6, 1'b1, "wr_c1_d6");
    do_sync(s);
    en = 3'b001;
    exp_add(s + 4, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "stag_c0_tick");
    wait_until(s + 3);
    en = 3'b011;
    wait_until(s + 5);
    do_sync(s2);
    exp_add(s2 + 2,  3'b000, 3'b010, 3'b010, 1'b0, 1'b0, "post_sync_c1_sq_hi");
    exp_add(s2 + 3,  3'b000, 3'b010, 3'b000, 1'b0, 1'b0, "post_sync_c1_sq_lo");
    exp_add(s2 + 4,  3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "post_sync_c0_t1");
    exp_add(s2 + 6,  3'b010, 3'b010, 3'b010, 1'b0, 1'b0, "post_sync_c1_t1");
    exp_add(s2 + 8,  3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "post_sync_c0_t2");
    exp_add(s2 + 12, 3'b011, 3'b011, 3'b011, 1'b0, 1'b0, "post_sync_both");
    wait_until(s2 + 12);
    en = '0;

    // en[0] low for 10 cycles at c=2: counter and sq hold
    do_sync(s);
    en = 3'b001;
    exp_add(s + 2,  3'b000, 3'b001, 3'b000, 1'b0, 1'b0, "pause_c2_sq");
    exp_add(s + 7,  3'b000, 3'b001, 3'b000, 1'b0, 1'b0, "pause_hold_sq");
    exp_add(s + 12, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, "pause_end_sq");
    exp_add(s + 13, 3'b000, 3'b001, 3'b000, 1'b0, 1'b0, "resume_c3_sq");
    exp_add(s + 14, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "resume_tick");
    exp_add(s + 18, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "resume_tick2");
    wait_until(s + 2);
    en = '0;
    wait_until(s + 12);
    en = 3'b001;
    wait_until(s + 18);
    en = '0;

    // Reset mid-period with a pending write
    do_sync(s);
    en = 3'b001;
    wait_until(s + 2);
    write_cfg(2'd0, 16'd9, 1'b1, "wr_d9_pending");
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_zero("async_rst_tick", tick);
    check_zero("async_rst_sq", sq);
    check_zero("async_rst_ack", {2'b00, cfg_if.cfg_ack});
    check_zero("async_rst_err", {2'b00, cfg_if.cfg_err});
    en = '0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    r = cyc;
    en = 3'b111;
    exp_add(r + 1,  3'b000, 3'b111, 3'b111, 1'b0, 1'b0, "rst_sq_c1");
    exp_add(r + 2,  3'b000, 3'b111, 3'b110, 1'b0, 1'b0, "rst_sq_c2");
    exp_add(r + 5,  3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "rst_c0_d5_t1");
    exp_add(r + 6,  3'b010, 3'b010, 3'b010, 1'b0, 1'b0, "rst_c1_d6_t1");
    exp_add(r + 8,  3'b100, 3'b100, 3'b100, 1'b0, 1'b0, "rst_c2_d8_t1");
    exp_add(r + 10, 3'b001, 3'b001, 3'b001, 1'b0, 1'b0, "rst_c0_d5_t2");
    exp_add(r + 12, 3'b010, 3'b010, 3'b010, 1'b0, 1'b0, "rst_c1_d6_t2");
    wait_until(r + 12);
    en = '0;
    wait_until(r + 16);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
